// File: rtl/lc3_interrupt_controller.sv
// lc3_interrupt_controller
//   Priority interrupt arbiter for the LC-3 microsequencer. Level requests
//   are masked by per-source enables and by the current PSR priority. The
//   highest-priority candidate wins, with ties going to the lowest index. The
//   winner's vector and priority are held stable until the microcode
//   acknowledges. Each acknowledge is followed by a fixed holdoff window.
//
// Ports
//   i_CLK       system clock, rising edge
//   i_Reset     synchronous active-high reset
//   i_IRQ       level request per source
//   i_IE        per-source interrupt enable
//   i_Src_Pri   3-bit priority per source, source k in [3k+2:3k]
//   i_PSR_Pri   current PSR priority
//   i_INT_Ack   microcode "take interrupt" pulse
//   o_INT       interrupt pending (registered)
//   o_INTV      vector of pending / last-taken interrupt (registered)
//   o_INT_Pri   priority of pending / last-taken interrupt (registered)
//   o_Ack_Src   one-hot one-cycle pulse naming the acknowledged source
//   o_Busy      high while pending or in holdoff
module lc3_interrupt_controller #(
    parameter int         N_SRC       = 4,
    parameter logic [7:0] VEC_BASE    = 8'h80,
    parameter int         ACK_HOLDOFF = 4
) (
    input  logic               i_CLK,
    input  logic               i_Reset,
    input  logic [N_SRC-1:0]   i_IRQ,
    input  logic [N_SRC-1:0]   i_IE,
    input  logic [3*N_SRC-1:0] i_Src_Pri,
    input  logic [2:0]         i_PSR_Pri,
    input  logic               i_INT_Ack,
    output logic               o_INT,
    output logic [7:0]         o_INTV,
    output logic [2:0]         o_INT_Pri,
    output logic [N_SRC-1:0]   o_Ack_Src,
    output logic               o_Busy
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {IDLE, PEND, HOLDOFF} state_t;

    state_t           state, state_next;
    logic [2:0]       src_pri [N_SRC];
    logic [N_SRC-1:0] cand;
    logic             any_cand;
    logic [IW-1:0]    win_idx;
    logic [2:0]       win_pri;
    logic [IW-1:0]    lat_idx;
    logic [3:0]       cnt;
    logic             lat_ok;
    logic             take_ack;
    logic             latch;
    logic             int_next;
    logic [N_SRC-1:0] ack_next;

    // Candidate set and winner. The scan runs from the top index down and
    // uses >=, so on a tie the lower index replaces the higher one.
    always_comb begin
        any_cand = 1'b0;
        win_idx  = '0;
        win_pri  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            src_pri[k] = i_Src_Pri[3*k +: 3];
            cand[k]    = i_IRQ[k] & i_IE[k] & (src_pri[k] > i_PSR_Pri);
        end
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (cand[k] && (!any_cand || src_pri[k] >= win_pri)) begin
                any_cand = 1'b1;
                win_idx  = IW'(k);
                win_pri  = src_pri[k];
            end
        end
    end

    // Acknowledge beats withdrawal, and withdrawal beats preemption.
    // Re-latching occurs on withdrawal (if another candidate exists) or on
    // strict preemption.
    assign lat_ok   = cand[lat_idx];
    assign take_ack = (state == PEND) && i_INT_Ack;
    assign latch    = ((state == IDLE) && any_cand) ||
                      ((state == PEND) && !i_INT_Ack && any_cand &&
                       (!lat_ok || (win_pri > o_INT_Pri)));

    // State register
    always_ff @(posedge i_CLK) begin
        if (i_Reset) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_cand) state_next = PEND;
            PEND: begin
                if (i_INT_Ack)                 state_next = HOLDOFF;
                else if (!lat_ok && !any_cand) state_next = IDLE;
            end
            HOLDOFF: if (cnt == 4'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        int_next = (state_next == PEND);
        ack_next = '0;
        if (take_ack) ack_next[lat_idx] = 1'b1;
    end

    assign o_Busy = (state != IDLE);

    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            o_INT     <= 1'b0;
            o_INTV    <= 8'h00;
            o_INT_Pri <= 3'd0;
            o_Ack_Src <= '0;
            lat_idx   <= '0;
            cnt       <= 4'd0;
        end else begin
            o_INT     <= int_next;
            o_Ack_Src <= ack_next;
            if (latch) begin
                lat_idx   <= win_idx;
                o_INTV    <= VEC_BASE + 8'(win_idx);
                o_INT_Pri <= win_pri;
            end
            // Loaded with ACK_HOLDOFF-1 so that the dwell, including the
            // cycle in which the counter reads zero, is ACK_HOLDOFF cycles.
            if (take_ack)
                cnt <= 4'(ACK_HOLDOFF - 1);
            else if ((state == HOLDOFF) && (cnt != 4'd0))
                cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_lc3_interrupt_controller.sv
module tb_lc3_interrupt_controller;

    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int VB   = 8'h80;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    irq, ie;
    logic [3*N-1:0]  spri;
    logic [2:0]      psr;
    logic            ack;
    logic            o_int;
    logic [7:0]      o_intv;
    logic [2:0]      o_ipri;
    logic [N-1:0]    o_acks;
    logic            o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lc3_interrupt_controller #(.N_SRC(N), .VEC_BASE(8'h80), .ACK_HOLDOFF(HOLD)) dut (
        .i_CLK(clk), .i_Reset(rst), .i_IRQ(irq), .i_IE(ie), .i_Src_Pri(spri),
        .i_PSR_Pri(psr), .i_INT_Ack(ack), .o_INT(o_int), .o_INTV(o_intv),
        .o_INT_Pri(o_ipri), .o_Ack_Src(o_acks), .o_Busy(o_busy)
    );

    typedef struct {
        bit       rst;
        bit [3:0] irq;
        bit [3:0] ie;
        bit [11:0] pri;
        bit [2:0] psr;
        bit       ack;
        bit       e_int;
        bit [7:0] e_intv;
        bit [2:0] e_pri;
        bit [3:0] e_acks;
        bit       e_busy;
    } vec_t;

    vec_t tbl[$];

    // ---------------- behavioural reference model ----------------
    bit       m_int;
    int       m_intv, m_pri, m_acks, m_lat, m_hold;
    bit       m_pend;

    function automatic int pri_of(input bit [11:0] p, input int k);
        return (p >> (3*k)) & 7;
    endfunction

    function automatic bit is_cand(input bit [3:0] q, input bit [3:0] e,
                                   input bit [11:0] p, input int ps, input int k);
        return q[k] && e[k] && (pri_of(p, k) > ps);
    endfunction

    // Highest priority wins; scanning upward with a strict compare keeps the
    // lowest index on a tie. Returns -1 when nobody qualifies.
    function automatic int best(input bit [3:0] q, input bit [3:0] e,
                                input bit [11:0] p, input int ps);
        int b = -1;
        for (int k = 0; k < N; k++)
            if (is_cand(q, e, p, ps, k) && (b < 0 || pri_of(p, k) > pri_of(p, b)))
                b = k;
        return b;
    endfunction

    task automatic model_step(input bit r, input bit [3:0] q, input bit [3:0] e,
                              input bit [11:0] p, input int ps, input bit a);
        int w;
        w = best(q, e, p, ps);
        m_acks = 0;
        if (r) begin
            m_int = 0; m_intv = 0; m_pri = 0; m_lat = 0; m_hold = 0; m_pend = 0;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (m_pend) begin
            if (a) begin
                m_acks = 1 << m_lat; m_int = 0; m_pend = 0; m_hold = HOLD;
            end else if (!is_cand(q, e, p, ps, m_lat)) begin
                if (w >= 0) begin
                    m_lat = w; m_intv = (VB + w) & 8'hFF; m_pri = pri_of(p, w);
                end else begin
                    m_pend = 0; m_int = 0;
                end
            end else if (w >= 0 && pri_of(p, w) > m_pri) begin
                m_lat = w; m_intv = (VB + w) & 8'hFF; m_pri = pri_of(p, w);
            end
        end else if (w >= 0) begin
            m_lat = w; m_intv = (VB + w) & 8'hFF; m_pri = pri_of(p, w);
            m_pend = 1; m_int = 1;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic apply(input bit r, input bit [3:0] q, input bit [3:0] e,
                         input bit [11:0] p, input bit [2:0] ps, input bit a);
        rst = r; irq = q; ie = e; spri = p; psr = ps; ack = a;
        @(posedge clk);
        model_step(r, q, e, p, int'(ps), a);
        #1;
    endtask

    function automatic bit [11:0] pk(input int p0, input int p1, input int p2, input int p3);
        return 12'((p3 << 9) | (p2 << 6) | (p1 << 3) | p0);
    endfunction

    function automatic vec_t mk(input bit r, input bit [3:0] q, input bit [3:0] e,
                                input bit [11:0] p, input bit [2:0] ps, input bit a,
                                input bit ei, input bit [7:0] ev, input bit [2:0] ep,
                                input bit [3:0] ea, input bit eb);
        vec_t v;
        v.rst = r; v.irq = q; v.ie = e; v.pri = p; v.psr = ps; v.ack = a;
        v.e_int = ei; v.e_intv = ev; v.e_pri = ep; v.e_acks = ea; v.e_busy = eb;
        return v;
    endfunction

    initial begin
        bit [11:0] pa, pb, pc, pd, pe;
        rst = 1'b1; irq = '0; ie = '0; spri = '0; psr = '0; ack = 1'b0;

        pa = pk(0, 4, 0, 0);
        pb = pk(5, 0, 5, 6);
        pc = pk(0, 2, 2, 7);
        pd = pk(4, 0, 3, 0);
        pe = pk(7, 7, 7, 7);
        // r  irq      ie       pri psr ack | int intv  pri acks    busy
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0,  0, 0,  0, 8'h00, 0, 4'b0000, 0)); // reset
        tbl.push_back(mk(0, 4'b0010, 4'b1111, pa, 0, 0,  1, 8'h81, 4, 4'b0000, 1)); // 1-cycle latency
        tbl.push_back(mk(0, 4'b0010, 4'b1111, pa, 0, 1,  0, 8'h81, 4, 4'b0010, 1)); // ack
        tbl.push_back(mk(0, 4'b0010, 4'b1111, pa, 0, 1,  0, 8'h81, 4, 4'b0000, 1)); // holdoff, ack ignored
        tbl.push_back(mk(0, 4'b0010, 4'b1111, pa, 0, 0,  0, 8'h81, 4, 4'b0000, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b1111, pa, 0, 0,  0, 8'h81, 4, 4'b0000, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b1111, pa, 0, 0,  0, 8'h81, 4, 4'b0000, 0)); // back to idle
        tbl.push_back(mk(0, 4'b0010, 4'b1111, pa, 0, 0,  1, 8'h81, 4, 4'b0000, 1)); // reassert
        tbl.push_back(mk(1, 4'b0010, 4'b1111, pa, 0, 0,  0, 8'h00, 0, 4'b0000, 0)); // reset mid-PEND
        tbl.push_back(mk(0, 4'b1101, 4'b1111, pb, 0, 0,  1, 8'h83, 6, 4'b0000, 1)); // highest pri
        tbl.push_back(mk(0, 4'b0101, 4'b1111, pb, 0, 0,  1, 8'h80, 5, 4'b0000, 1)); // withdraw, tie->low idx
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0,  0, 0,  0, 8'h00, 0, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b0010, 4'b1111, pc, 0, 0,  1, 8'h81, 2, 4'b0000, 1));
        tbl.push_back(mk(0, 4'b1010, 4'b1111, pc, 0, 0,  1, 8'h83, 7, 4'b0000, 1)); // preempt
        tbl.push_back(mk(0, 4'b1110, 4'b1111, pc, 0, 0,  1, 8'h83, 7, 4'b0000, 1)); // low pri, no change
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0,  0, 0,  0, 8'h00, 0, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b1111, pd, 0, 0,  1, 8'h82, 3, 4'b0000, 1));
        tbl.push_back(mk(0, 4'b0100, 4'b1111, pd, 0, 1,  0, 8'h82, 3, 4'b0100, 1)); // ack src 2
        tbl.push_back(mk(1, 4'b0100, 4'b1111, pd, 0, 0,  0, 8'h00, 0, 4'b0000, 0)); // reset mid-HOLDOFF
        tbl.push_back(mk(0, 4'b0001, 4'b1111, pd, 0, 0,  1, 8'h80, 4, 4'b0000, 1));
        tbl.push_back(mk(0, 4'b0001, 4'b1111, pd, 4, 0,  0, 8'h80, 4, 4'b0000, 0)); // PSR withdrawal
        tbl.push_back(mk(0, 4'b0001, 4'b1111, pd, 0, 0,  1, 8'h80, 4, 4'b0000, 1));
        tbl.push_back(mk(0, 4'b0001, 4'b1111, pd, 4, 1,  0, 8'h80, 4, 4'b0001, 1)); // ack beats withdrawal
        tbl.push_back(mk(1, 4'b1111, 4'b0000, pe, 0, 0,  0, 8'h00, 0, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, pe, 0, 0,  0, 8'h00, 0, 4'b0000, 0)); // IE masks all
        tbl.push_back(mk(0, 4'b1111, 4'b0000, pe, 0, 0,  0, 8'h00, 0, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, pe, 7, 0,  0, 8'h00, 0, 4'b0000, 0)); // pri == PSR
        tbl.push_back(mk(0, 4'b1111, 4'b1111, pe, 6, 0,  1, 8'h80, 7, 4'b0000, 1)); // 4-way tie
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0,  0, 0,  0, 8'h00, 0, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 0,  0, 0,  0, 8'h00, 0, 4'b0000, 0)); // pri 0 never wins

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].irq, tbl[i].ie, tbl[i].pri, tbl[i].psr, tbl[i].ack);
            chk($sformatf("vec%0d int", i),  int'(o_int),  int'(tbl[i].e_int));
            chk($sformatf("vec%0d intv", i), int'(o_intv), int'(tbl[i].e_intv));
            chk($sformatf("vec%0d pri", i),  int'(o_ipri), int'(tbl[i].e_pri));
            chk($sformatf("vec%0d acks", i), int'(o_acks), int'(tbl[i].e_acks));
            chk($sformatf("vec%0d busy", i), int'(o_busy), int'(tbl[i].e_busy));
        end

        // Randomized run against the reference model.
        apply(1, '0, '0, '0, 0, 0);
        for (int c = 0; c < 600; c++) begin
            bit        r, a;
            bit [3:0]  q, e;
            bit [11:0] p;
            bit [2:0]  ps;
            r  = ($urandom_range(0, 99) < 2);
            q  = 4'($urandom);
            e  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            p  = (c % 16 < 12) ? spri : 12'($urandom);
            ps = 3'($urandom_range(0, 4));
            a  = ($urandom_range(0, 99) < 25);
            apply(r, q, e, p, ps, a);
            chk($sformatf("rnd%0d int", c),  int'(o_int),  int'(m_int));
            chk($sformatf("rnd%0d intv", c), int'(o_intv), m_intv);
            chk($sformatf("rnd%0d pri", c),  int'(o_ipri), m_pri);
            chk($sformatf("rnd%0d acks", c), int'(o_acks), m_acks);
            chk($sformatf("rnd%0d busy", c), int'(o_busy), int'(m_pend || m_hold > 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lc3_interrupt_controller.md
Name: lc3_interrupt_controller

Overview:
Priority interrupt arbiter for the LC-3 core. It collects level-sensitive requests from up to 8 memory-mapped devices, masks them by per-device IE bits and the current PSR priority, and picks a single winner. It drives INT into the microsequencer's interrupt branch condition and presents a stable INTV vector and priority to the datapath until the microcode acknowledges the interrupt. After each acknowledge it runs a fixed holdoff window while the microcode raises PSR priority.

Parameters:
N_SRC, 4, number of interrupt sources; legal range 1..8.
VEC_BASE, 8'h80, vector of source 0; source k uses VEC_BASE+k, truncated to 8 bits.
ACK_HOLDOFF, 4, cycles after acknowledge during which no new arbitration occurs; legal range 1..15.

Ports:
i_CLK  input  1  system clock; all state changes on the rising edge.
i_Reset  input  1  synchronous, active-high reset.
i_IRQ  input  N_SRC  level request per source; held by the device until it is serviced.
i_IE  input  N_SRC  per-source interrupt enable (device status register bit 14).
i_Src_Pri  input  3*N_SRC  priority of source k in bits [3k+2:3k]; unsigned.
i_PSR_Pri  input  3  current PSR[10:8] priority.
i_INT_Ack  input  1  control-store pulse asserted in the microstate that loads the vector (take interrupt).
o_INT  output  1  interrupt pending to the microsequencer; registered.
o_INTV  output  8  vector of the pending or last-taken interrupt; registered.
o_INT_Pri  output  3  priority of the pending or last-taken interrupt; registered. The datapath loads this into PSR.
o_Ack_Src  output  N_SRC  one-hot, one-cycle pulse naming the acknowledged source; registered.
o_Busy  output  1  high in PEND or HOLDOFF.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, o_INT=0, o_INTV=8'h00, o_INT_Pri=0, o_Ack_Src=0, holdoff counter=0.
  - Reset mid-PEND or mid-HOLDOFF abandons the operation with no ack pulse.
- Candidate set, combinational each cycle:
  - source k is a candidate iff i_IRQ[k] & i_IE[k] & (pri_k > i_PSR_Pri), using a strict unsigned compare.
  - A priority-0 source can therefore never interrupt.
- Winner selection: highest pri_k; ties go to the lowest index k.
- States: IDLE, PEND, HOLDOFF.
- IDLE:
  - If any candidate exists, on the next edge: latch the winner index, set o_INTV=VEC_BASE+k, o_INT_Pri=pri_k, o_INT=1, go to PEND.
  - Latency from request to o_INT is one cycle.
  - i_INT_Ack is ignored in IDLE.
- PEND, evaluated in this priority order:
  1. Acknowledge: if i_INT_Ack=1, then next edge sets o_INT=0 and o_Ack_Src=one-hot(latched k) for exactly one cycle, loads counter=ACK_HOLDOFF-1, and goes to HOLDOFF. o_INTV and o_INT_Pri hold the acknowledged values. Ack beats withdrawal and preemption in the same cycle.
  2. Withdrawal: if the latched source is no longer a candidate (IRQ or IE dropped, or i_PSR_Pri >= latched pri), then:
     - if another candidate exists, next edge re-latches that winner and stays in PEND with o_INT=1;
     - otherwise next edge sets o_INT=0, keeps o_INTV and o_INT_Pri, and goes to IDLE.
  3. Preemption: if the winner has priority strictly greater than the latched pri, next edge re-latches the winner (o_INTV and o_INT_Pri update) and o_INT stays 1. An equal-priority lower-index source does not preempt.
- HOLDOFF:
  - o_INT=0 and no arbitration.
  - The counter decrements each cycle; when it is 0, next edge goes to IDLE.
  - Total HOLDOFF dwell is ACK_HOLDOFF cycles.
  - i_INT_Ack is ignored.
- o_INTV and o_INT_Pri change only on a latch or on reset. They are stable whenever o_INT=1 and on the ack cycle.
- o_Busy = (state != IDLE).

Test Plan:
- Reset, then i_IRQ=4'b0010, i_IE=4'b1111, pri1=4, PSR_Pri=0 -> o_INT=1 one cycle later, o_INTV=8'h81, o_INT_Pri=4.
- Sources 0 and 2 both at pri 5, source 3 at pri 6, PSR_Pri=0 -> o_INTV=8'h83. Then drop IRQ3 -> re-latch to 8'h80 with o_INT held 1 (tie goes to lowest index).
- Pending 8'h81 at pri 2, then source 3 rises at pri 7 -> o_INTV=8'h83, o_INT_Pri=7 next cycle. A source rising at pri 2 in PEND causes no change.
- Pulse i_INT_Ack with o_INT=1, o_INTV=8'h82 -> next cycle o_INT=0, o_Ack_Src=4'b0100 for one cycle, o_Busy=1 for 4 cycles. With IRQ2 still high and PSR_Pri=0, o_INT reasserts on cycle 6 after ack.
- PSR_Pri raised to 4 while pending at pri 4 -> o_INT=0 next cycle, state IDLE, o_INTV unchanged. Ack in the same cycle as the withdrawal -> ack wins and o_Ack_Src pulses.
- Assert i_Reset mid-HOLDOFF and mid-PEND -> next edge all outputs take reset values, no o_Ack_Src pulse. i_IE=0 with i_IRQ all high -> o_INT stays 0.
